// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I decode definitions.
//   - opcode constants (instr[6:0])
//   - alu_op_t: 4-bit ALU operation encoding consumed by EX
//   - imm_sel_t: immediate format selector for imm_gen
//   - ctrl_t: per-slot control bits carried in the ID/EX register
//   - alu_decode(): funct3/alt-bit to alu_op_t for OP and OP-IMM
//   - imm_sel_of(): opcode to immediate format
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  typedef struct packed {
    logic alu_src_imm;
    logic alu_src_pc;
    logic mem_rd;
    logic mem_wr;
    logic reg_we;
    logic branch;
    logic jal;
    logic jalr;
    logic illegal;
  } ctrl_t;

  // alt is funct7[5]; callers mask it for OP-IMM so only SRAI sees it.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic imm_sel_t imm_sel_of(input logic [6:0] opc);
    case (opc)
      OP_STORE:        return IMM_S;
      OP_BRANCH:       return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:          return IMM_J;
      default:         return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction.
//   instr : instruction word
//   imm   : immediate for the instruction's format, sign-extended to XLEN
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_sel_of(instr[6:0]))
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  // signed size cast sign-extends to XLEN
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode stage plus ID/EX pipeline register.
//   in : clk, rst (sync, active high), if_valid/if_instr/if_pc from IF/ID,
//        ex_flush from EX, rf_rdout1/2 from the (asynchronous) regfile
//   out: rf_rs1/rf_rs2 read addresses, stall (load-use), the registered
//        ex_* slot for EX, perf_stall_cnt/perf_flush_cnt
// Build option: define ID_PERF_CNT_EN to get the stall/flush counters;
// otherwise both perf ports are tied to 0.
// JAL/JALR: ex_imm carries the jump offset; EX substitutes the constant 4 on
// the ALU B input when ex_jal|ex_jalr so the ALU yields the link PC+4.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              ex_flush,
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic [XLEN-1:0]   rf_rdout1,
  input  logic [XLEN-1:0]   rf_rdout2,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [3:0]        ex_alu_op,
  output logic              ex_alu_src_imm,
  output logic              ex_alu_src_pc,
  output logic [2:0]        ex_funct3,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_reg_we,
  output logic              ex_branch,
  output logic              ex_jal,
  output logic              ex_jalr,
  output logic              ex_illegal,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  logic [6:0]    opc;
  logic [4:0]    rd;
  logic [2:0]    f3;
  logic          f7b5;
  logic          use_rs1, use_rs2;
  ctrl_t         dc;
  alu_op_t       aop;
  logic [XLEN-1:0] imm;
  ctrl_t         ex_ctrl;
  logic          load_slot;

  assign opc    = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign f3     = if_instr[14:12];
  assign rf_rs1 = if_instr[19:15];
  assign rf_rs2 = if_instr[24:20];
  assign f7b5   = if_instr[30];

  imm_gen #(.XLEN(XLEN)) u_imm (.instr(if_instr), .imm(imm));

  always_comb begin
    dc      = '0;
    aop     = ALU_ADD;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OP_LUI:    begin dc.reg_we = 1'b1; dc.alu_src_imm = 1'b1; aop = ALU_PASS_B; end
      OP_AUIPC:  begin dc.reg_we = 1'b1; dc.alu_src_imm = 1'b1; dc.alu_src_pc = 1'b1; end
      OP_JAL:    begin dc.reg_we = 1'b1; dc.alu_src_pc = 1'b1; dc.jal = 1'b1; end
      OP_JALR:   begin dc.reg_we = 1'b1; dc.alu_src_pc = 1'b1; dc.jalr = 1'b1; use_rs1 = 1'b1; end
      OP_BRANCH: begin dc.branch = 1'b1; aop = ALU_SUB; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LOAD:   begin dc.mem_rd = 1'b1; dc.reg_we = 1'b1; dc.alu_src_imm = 1'b1; use_rs1 = 1'b1; end
      OP_STORE:  begin dc.mem_wr = 1'b1; dc.alu_src_imm = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM: begin
        dc.reg_we = 1'b1; dc.alu_src_imm = 1'b1; use_rs1 = 1'b1;
        // imm[10] only selects arithmetic shift for SRAI; ADDI etc. ignore it
        aop = alu_decode(f3, f7b5 & (f3 == 3'd5));
      end
      OP_OP: begin
        dc.reg_we = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        aop = alu_decode(f3, f7b5);
      end
      OP_FENCE, OP_SYSTEM: ;
      default:   dc.illegal = 1'b1;
    endcase
    if (rd == 5'd0) dc.reg_we = 1'b0;
  end

  assign load_slot = ex_valid & ex_ctrl.mem_rd & (ex_rd != 5'd0);
  assign stall = if_valid & load_slot & ~ex_flush &
                 ((use_rs1 & (ex_rd == rf_rs1)) | (use_rs2 & (ex_rd == rf_rs2)));

  // Data fields always follow ID; only valid and control are squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_alu_op  <= '0;
      ex_funct3  <= '0;
    end else begin
      ex_valid   <= if_valid & ~ex_flush & ~stall;
      ex_ctrl    <= (if_valid & ~ex_flush & ~stall) ? dc : '0;
      ex_pc      <= if_pc;
      ex_rs1_val <= rf_rdout1;
      ex_rs2_val <= rf_rdout2;
      ex_imm     <= imm;
      ex_rs1     <= rf_rs1;
      ex_rs2     <= rf_rs2;
      ex_rd      <= rd;
      ex_alu_op  <= aop;
      ex_funct3  <= f3;
    end
  end

  assign ex_alu_src_imm = ex_ctrl.alu_src_imm;
  assign ex_alu_src_pc  = ex_ctrl.alu_src_pc;
  assign ex_mem_rd      = ex_ctrl.mem_rd;
  assign ex_mem_wr      = ex_ctrl.mem_wr;
  assign ex_reg_we      = ex_ctrl.reg_we;
  assign ex_branch      = ex_ctrl.branch;
  assign ex_jal         = ex_ctrl.jal;
  assign ex_jalr        = ex_ctrl.jalr;
  assign ex_illegal     = ex_ctrl.illegal;

`ifdef ID_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall)               stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (ex_flush & if_valid) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int PERF_W = 32;

  localparam logic [31:0] I_ADDI  = 32'h00700293; // addi x5,x0,7
  localparam logic [31:0] I_LW6   = 32'h0000A303; // lw   x6,0(x1)
  localparam logic [31:0] I_ADD76 = 32'h002303B3; // add  x7,x6,x2
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD70 = 32'h002003B3; // add  x7,x0,x2
  localparam logic [31:0] I_SW6   = 32'h0061A023; // sw   x6,0(x3)
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3; // beq  x0,x0,-4
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_SRAI  = 32'h40315093; // srai x1,x2,3
  localparam logic [31:0] I_ADDIN = 32'hC0000093; // addi x1,x0,-1024
  localparam logic [31:0] I_LUI   = 32'h123451B7; // lui  x3,0x12345
  localparam logic [31:0] I_JAL   = 32'h0080006F; // jal  x0,8
  localparam logic [31:0] I_NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  logic if_valid;
  logic [31:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic ex_flush;
  logic [4:0] rf_rs1, rf_rs2;
  logic [XLEN-1:0] rf_rdout1, rf_rdout2;
  logic stall, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_alu_op;
  logic ex_alu_src_imm, ex_alu_src_pc;
  logic [2:0] ex_funct3;
  logic ex_mem_rd, ex_mem_wr, ex_reg_we, ex_branch, ex_jal, ex_jalr, ex_illegal;
  logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;

  int total = 0;
  int bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  // regfile stand-in: value encodes the register index read
  assign rf_rdout1 = 32'hA000_0000 | {27'd0, rf_rs1};
  assign rf_rdout2 = 32'hB000_0000 | {27'd0, rf_rs2};

  id_ex_stage #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_flush(ex_flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rdout1(rf_rdout1), .rf_rdout2(rf_rdout2), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm), .ex_alu_src_pc(ex_alu_src_pc),
    .ex_funct3(ex_funct3), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_reg_we(ex_reg_we), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_illegal(ex_illegal), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl);
    if_valid = v; if_instr = ins; if_pc = pc; ex_flush = fl;
    #1;
  endtask

  task automatic test_perf(input string tag);
`ifdef ID_PERF_CNT_EN
    total++; if (perf_stall_cnt !== PERF_W'(exp_stall)) begin bad++; $display("FAIL %s perf_stall_cnt got %0d want %0d", tag, perf_stall_cnt, exp_stall); end
    total++; if (perf_flush_cnt !== PERF_W'(exp_flush)) begin bad++; $display("FAIL %s perf_flush_cnt got %0d want %0d", tag, perf_flush_cnt, exp_flush); end
`else
    total++; if (perf_stall_cnt !== '0) begin bad++; $display("FAIL %s perf_stall_cnt got %0d want 0", tag, perf_stall_cnt); end
    total++; if (perf_flush_cnt !== '0) begin bad++; $display("FAIL %s perf_flush_cnt got %0d want 0", tag, perf_flush_cnt); end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    put(1'b1, I_ADDI, 32'h100, 1'b0);
    tick(); tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset ex_valid got %b want 0", ex_valid); end
    total++; if ({ex_pc, ex_rs1_val, ex_rs2_val, ex_imm} !== '0) begin bad++; $display("FAIL reset data got %h want 0", {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm}); end
    total++; if ({ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_funct3} !== '0) begin bad++; $display("FAIL reset fields got %h want 0", {ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_funct3}); end
    total++; if ({ex_alu_src_imm, ex_alu_src_pc, ex_mem_rd, ex_mem_wr, ex_reg_we, ex_branch, ex_jal, ex_jalr, ex_illegal} !== 9'd0) begin
      bad++; $display("FAIL reset ctrl got %b want 0", {ex_alu_src_imm, ex_alu_src_pc, ex_mem_rd, ex_mem_wr, ex_reg_we, ex_branch, ex_jal, ex_jalr, ex_illegal}); end
    exp_stall = 0; exp_flush = 0;
    test_perf("reset");
    rst = 1'b0;
  endtask

  task automatic test_addi();
    put(1'b1, I_ADDI, 32'h100, 1'b0);
    tick();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL addi ex_valid got %b want 1", ex_valid); end
    total++; if (ex_rd !== 5'd5) begin bad++; $display("FAIL addi ex_rd got %0d want 5", ex_rd); end
    total++; if (ex_imm !== 32'd7) begin bad++; $display("FAIL addi ex_imm got %h want 7", ex_imm); end
    total++; if (ex_alu_op !== 4'd0) begin bad++; $display("FAIL addi ex_alu_op got %0d want 0", ex_alu_op); end
    total++; if ({ex_alu_src_imm, ex_reg_we, ex_mem_rd} !== 3'b110) begin bad++; $display("FAIL addi ctrl got %b want 110", {ex_alu_src_imm, ex_reg_we, ex_mem_rd}); end
    total++; if (ex_pc !== 32'h100) begin bad++; $display("FAIL addi ex_pc got %h want 100", ex_pc); end
    total++; if (ex_rs1_val !== 32'hA000_0000) begin bad++; $display("FAIL addi ex_rs1_val got %h want a0000000", ex_rs1_val); end
  endtask

  task automatic test_load_use();
    put(1'b1, I_LW6, 32'h104, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu pre stall got %b want 0", stall); end
    tick();
    total++; if ({ex_mem_rd, ex_rd} !== {1'b1, 5'd6}) begin bad++; $display("FAIL lu lw slot got %b/%0d want 1/6", ex_mem_rd, ex_rd); end
    put(1'b1, I_ADD76, 32'h108, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu stall got %b want 1", stall); end
    exp_stall++;
    tick();
    total++; if ({ex_valid, ex_reg_we} !== 2'b00) begin bad++; $display("FAIL lu bubble got %b want 00", {ex_valid, ex_reg_we}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu stall2 got %b want 0", stall); end
    tick();
    total++; if ({ex_valid, ex_rs1, ex_rs2, ex_rd} !== {1'b1, 5'd6, 5'd2, 5'd7}) begin
      bad++; $display("FAIL lu add fields got %b/%0d/%0d/%0d want 1/6/2/7", ex_valid, ex_rs1, ex_rs2, ex_rd); end
    total++; if ({ex_rs1_val, ex_rs2_val} !== {32'hA000_0006, 32'hB000_0002}) begin
      bad++; $display("FAIL lu operands got %h %h want a0000006 b0000002", ex_rs1_val, ex_rs2_val); end
    total++; if (ex_pc !== 32'h108) begin bad++; $display("FAIL lu ex_pc got %h want 108", ex_pc); end
    test_perf("load_use");
  endtask

  task automatic test_x0_no_stall();
    put(1'b1, I_LW0, 32'h10C, 1'b0);
    tick();
    total++; if ({ex_mem_rd, ex_reg_we} !== 2'b10) begin bad++; $display("FAIL x0 lw ctrl got %b want 10", {ex_mem_rd, ex_reg_we}); end
    put(1'b1, I_ADD70, 32'h110, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0 stall got %b want 0", stall); end
    tick();
    total++; if ({ex_valid, ex_rd} !== {1'b1, 5'd7}) begin bad++; $display("FAIL x0 add got %b/%0d want 1/7", ex_valid, ex_rd); end
  endtask

  task automatic test_store_dep();
    put(1'b1, I_LW6, 32'h114, 1'b0);
    tick();
    put(1'b1, I_SW6, 32'h118, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sw stall got %b want 1", stall); end
    exp_stall++;
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL sw bubble got %b want 0", ex_valid); end
    tick();
    total++; if ({ex_valid, ex_mem_wr, ex_reg_we, ex_imm} !== {3'b110, 32'd0}) begin
      bad++; $display("FAIL sw slot got %b%b%b imm %h want 110 imm 0", ex_valid, ex_mem_wr, ex_reg_we, ex_imm); end
    test_perf("store");
  endtask

  task automatic test_flush();
    put(1'b1, I_LW6, 32'h11C, 1'b0);
    tick();
    put(1'b1, I_ADD76, 32'h120, 1'b1);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush stall got %b want 0", stall); end
    exp_flush++;
    tick();
    total++; if ({ex_valid, ex_mem_rd, ex_reg_we} !== 3'b000) begin bad++; $display("FAIL flush slot got %b want 000", {ex_valid, ex_mem_rd, ex_reg_we}); end
    put(1'b0, I_NOP, 32'h124, 1'b0);
    test_perf("flush");
  endtask

  task automatic test_branch();
    put(1'b1, I_BEQ, 32'h200, 1'b0);
    tick();
    total++; if (ex_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL beq ex_imm got %h want fffffffc", ex_imm); end
    total++; if ({ex_valid, ex_branch, ex_reg_we} !== 3'b110) begin bad++; $display("FAIL beq ctrl got %b want 110", {ex_valid, ex_branch, ex_reg_we}); end
    total++; if (ex_alu_op !== 4'd1) begin bad++; $display("FAIL beq alu_op got %0d want 1", ex_alu_op); end
  endtask

  task automatic test_illegal();
    put(1'b1, I_ILL, 32'h204, 1'b0);
    tick();
    total++; if ({ex_valid, ex_illegal, ex_reg_we, ex_mem_rd, ex_mem_wr} !== 5'b11000) begin
      bad++; $display("FAIL illegal ctrl got %b want 11000", {ex_valid, ex_illegal, ex_reg_we, ex_mem_rd, ex_mem_wr}); end
  endtask

  task automatic test_alu_ops();
    put(1'b1, I_SRAI, 32'h300, 1'b0); tick();
    total++; if (ex_alu_op !== 4'd7) begin bad++; $display("FAIL srai alu_op got %0d want 7", ex_alu_op); end
    put(1'b1, I_ADDIN, 32'h304, 1'b0); tick();
    total++; if ({ex_alu_op, ex_imm} !== {4'd0, 32'hFFFF_FC00}) begin bad++; $display("FAIL addi_neg got %0d %h want 0 fffffc00", ex_alu_op, ex_imm); end
    put(1'b1, I_LUI, 32'h308, 1'b0); tick();
    total++; if ({ex_alu_op, ex_imm, ex_reg_we} !== {4'd10, 32'h1234_5000, 1'b1}) begin
      bad++; $display("FAIL lui got %0d %h %b want 10 12345000 1", ex_alu_op, ex_imm, ex_reg_we); end
    put(1'b1, I_JAL, 32'h30C, 1'b0); tick();
    total++; if ({ex_jal, ex_alu_src_pc, ex_alu_src_imm, ex_reg_we, ex_imm} !== {4'b1100, 32'd8}) begin
      bad++; $display("FAIL jal got %b%b%b%b %h want 1100 8", ex_jal, ex_alu_src_pc, ex_alu_src_imm, ex_reg_we, ex_imm); end
    put(1'b1, I_NOP, 32'h310, 1'b0); tick();
    total++; if ({ex_valid, ex_reg_we} !== 2'b10) begin bad++; $display("FAIL nop got %b want 10", {ex_valid, ex_reg_we}); end
    put(1'b0, I_LUI, 32'h314, 1'b0); tick();
    total++; if ({ex_valid, ex_reg_we, ex_alu_src_imm} !== 3'b000) begin bad++; $display("FAIL invalid got %b want 000", {ex_valid, ex_reg_we, ex_alu_src_imm}); end
  endtask

  task automatic test_reset_mid_stall();
    put(1'b1, I_LW6, 32'h400, 1'b0);
    tick();
    put(1'b1, I_ADD76, 32'h404, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms stall got %b want 1", stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if ({ex_valid, ex_mem_rd, stall} !== 3'b000) begin bad++; $display("FAIL rms state got %b want 000", {ex_valid, ex_mem_rd, stall}); end
    total++; if ({ex_pc, ex_rs1_val, ex_imm, ex_rd} !== '0) begin bad++; $display("FAIL rms data got %h want 0", {ex_pc, ex_rs1_val, ex_imm, ex_rd}); end
    exp_stall = 0; exp_flush = 0;
    test_perf("rst_mid_stall");
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = I_NOP; if_pc = '0; ex_flush = 1'b0;
    test_reset();
    test_addi();
    test_load_use();
    test_x0_no_stall();
    test_store_dep();
    test_flush();
    test_branch();
    test_illegal();
    test_alu_ops();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
